// File: rtl/ob_writeback_if.sv
// Bundle between the masker/output-select stage, the A/M RAMs and the write-back stage.
// The write-back stage takes the slave side; the master side drives results and RAM read data.
interface ob_writeback_if #(
    parameter int AW = 10,
    parameter int MW = 5
);
    logic [31:0]   ob;
    logic          state_write;
    logic          stall;
    logic          dest_a;
    logic          dest_m;
    logic [AW-1:0] adest;
    logic [MW-1:0] mdest;
    logic [AW-1:0] aadr;
    logic [MW-1:0] madr;
    logic [31:0]   amem_raw;
    logic [31:0]   mmem_raw;
    logic [31:0]   a_out;
    logic [31:0]   m_out;
    logic          amem_we;
    logic [AW-1:0] amem_wadr;
    logic [31:0]   amem_wdata;
    logic          mmem_we;
    logic [MW-1:0] mmem_wadr;
    logic [31:0]   mmem_wdata;

    modport slave (
        input  ob, state_write, stall, dest_a, dest_m, adest, mdest,
               aadr, madr, amem_raw, mmem_raw,
        output a_out, m_out, amem_we, amem_wadr, amem_wdata,
               mmem_we, mmem_wadr, mmem_wdata
    );

    modport master (
        output ob, state_write, stall, dest_a, dest_m, adest, mdest,
               aadr, madr, amem_raw, mmem_raw,
        input  a_out, m_out, amem_we, amem_wadr, amem_wdata,
               mmem_we, mmem_wadr, mmem_wdata
    );
endinterface

// File: rtl/ob_writeback.sv
// OB write-back latch: holds one microcycle's result, writes A/M RAM at the next capture,
// and bypasses the pending value to the A/M operand reads meanwhile.
module ob_writeback #(
    parameter int AW = 10,
    parameter int MW = 5
) (
    input  logic           clk,
    input  logic           reset,
    ob_writeback_if.slave  wb
);
    logic [31:0]   wb_data_q,  wb_data_d;
    logic [AW-1:0] wb_aadr_q,  wb_aadr_d;
    logic [MW-1:0] wb_madr_q,  wb_madr_d;
    logic          a_pend_q,   a_pend_d;
    logic          m_pend_q,   m_pend_d;
    logic          capture;

    assign capture = wb.state_write & ~wb.stall;

    // An M-only destination also lands in A at the zero-extended M address.
    always_comb begin
        wb_data_d = wb_data_q;
        wb_aadr_d = wb_aadr_q;
        wb_madr_d = wb_madr_q;
        a_pend_d  = a_pend_q;
        m_pend_d  = m_pend_q;
        if (capture) begin
            wb_data_d = wb.ob;
            wb_aadr_d = wb.dest_a ? wb.adest : AW'(wb.mdest);
            wb_madr_d = wb.mdest;
            a_pend_d  = wb.dest_a | wb.dest_m;
            m_pend_d  = wb.dest_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data_q <= '0;
            wb_aadr_q <= '0;
            wb_madr_q <= '0;
            a_pend_q  <= 1'b0;
            m_pend_q  <= 1'b0;
        end else begin
            wb_data_q <= wb_data_d;
            wb_aadr_q <= wb_aadr_d;
            wb_madr_q <= wb_madr_d;
            a_pend_q  <= a_pend_d;
            m_pend_q  <= m_pend_d;
        end
    end

    // The RAM write retires on the same edge that loads the next result.
    assign wb.amem_we    = a_pend_q & capture;
    assign wb.amem_wadr  = wb_aadr_q;
    assign wb.amem_wdata = wb_data_q;
    assign wb.mmem_we    = m_pend_q & capture;
    assign wb.mmem_wadr  = wb_madr_q;
    assign wb.mmem_wdata = wb_data_q;

    assign wb.a_out = (a_pend_q && (wb_aadr_q == wb.aadr)) ? wb_data_q : wb.amem_raw;
    assign wb.m_out = (m_pend_q && (wb_madr_q == wb.madr)) ? wb_data_q : wb.mmem_raw;
endmodule

// File: tb/tb_ob_writeback.sv
// Bench for ob_writeback: directed scenarios then random traffic, checked against an
// architectural memory model (what a read should see) and a committed-RAM model.
module tb_ob_writeback;
    localparam int AW = 10;
    localparam int MW = 5;

    logic clk;
    logic reset;

    ob_writeback_if #(.AW(AW), .MW(MW)) bus ();

    ob_writeback #(.AW(AW), .MW(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ram_*: contents the RAMs really hold; arch_*: what an operand read must return.
    logic [31:0]   ram_a  [0:(1<<AW)-1];
    logic [31:0]   arch_a [0:(1<<AW)-1];
    logic [31:0]   ram_m  [0:(1<<MW)-1];
    logic [31:0]   arch_m [0:(1<<MW)-1];

    // One outstanding result awaiting its RAM write.
    logic          pa, pm;
    logic [AW-1:0] paddr;
    logic [MW-1:0] pmaddr;
    logic [31:0]   pdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_raw();
        bus.amem_raw = ram_a[bus.aadr];
        bus.mmem_raw = ram_m[bus.madr];
    endtask

    task automatic cycle(input logic sw, input logic st, input logic da, input logic dm,
                         input logic [AW-1:0] ad, input logic [MW-1:0] md,
                         input logic [AW-1:0] aa, input logic [MW-1:0] ma,
                         input logic [31:0] obv);
        logic cap;
        bus.state_write = sw;
        bus.stall       = st;
        bus.dest_a      = da;
        bus.dest_m      = dm;
        bus.adest       = ad;
        bus.mdest       = md;
        bus.aadr        = aa;
        bus.madr        = ma;
        bus.ob          = obv;
        #1;
        drive_raw();
        #1;
        cap = sw & ~st;
        check("amem_we", 32'(bus.amem_we), 32'(pa & cap));
        check("mmem_we", 32'(bus.mmem_we), 32'(pm & cap));
        if (pa & cap) begin
            check("amem_wadr", 32'(bus.amem_wadr), 32'(paddr));
            check("amem_wdata", bus.amem_wdata, pdata);
        end
        if (pm & cap) begin
            check("mmem_wadr", 32'(bus.mmem_wadr), 32'(pmaddr));
            check("mmem_wdata", bus.mmem_wdata, pdata);
        end
        check("a_out", bus.a_out, arch_a[aa]);
        check("m_out", bus.m_out, arch_m[ma]);
        @(posedge clk);
        if (cap) begin
            if (pa) ram_a[paddr] = pdata;
            if (pm) ram_m[pmaddr] = pdata;
            pa     = da | dm;
            pm     = dm;
            paddr  = da ? ad : {{(AW-MW){1'b0}}, md};
            pmaddr = md;
            pdata  = obv;
            if (pa) arch_a[paddr] = obv;
            if (pm) arch_m[md] = obv;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pa = 1'b0;
        pm = 1'b0;
        paddr = '0;
        pmaddr = '0;
        pdata = '0;
        for (int i = 0; i < (1<<AW); i++) arch_a[i] = ram_a[i];
        for (int i = 0; i < (1<<MW); i++) arch_m[i] = ram_m[i];
        #1;
        drive_raw();
        #1;
        check("rst_amem_we", 32'(bus.amem_we), 32'd0);
        check("rst_mmem_we", 32'(bus.mmem_we), 32'd0);
        check("rst_amem_wadr", 32'(bus.amem_wadr), 32'd0);
        check("rst_mmem_wadr", 32'(bus.mmem_wadr), 32'd0);
        check("rst_amem_wdata", bus.amem_wdata, 32'd0);
        check("rst_mmem_wdata", bus.mmem_wdata, 32'd0);
        check("rst_a_out", bus.a_out, bus.amem_raw);
        check("rst_m_out", bus.m_out, bus.mmem_raw);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.state_write = 1'b0;
        bus.stall = 1'b0;
        bus.dest_a = 1'b0;
        bus.dest_m = 1'b0;
        bus.adest = '0;
        bus.mdest = '0;
        bus.aadr = '0;
        bus.madr = '0;
        bus.ob = '0;
        for (int i = 0; i < (1<<AW); i++) ram_a[i] = $urandom;
        for (int i = 0; i < (1<<MW); i++) ram_m[i] = $urandom;
        @(negedge clk);
        do_reset();

        // Reset with a write pending: the write must be dropped.
        cycle(1, 0, 1, 0, 10'h123, 5'h00, 10'h123, 5'h00, 32'hDEADBEEF);
        do_reset();
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h123, 5'h00, 32'h0);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h123, 5'h00, 32'h0);

        // Basic A write, then no destination.
        cycle(1, 0, 1, 0, 10'h045, 5'h00, 10'h045, 5'h00, 32'h12345678);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h045, 5'h00, 32'h0);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h045, 5'h00, 32'h0);

        // M write mirrored into A.
        cycle(1, 0, 0, 1, 10'h000, 5'h1F, 10'h01F, 5'h1F, 32'hA5A5A5A5);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h01F, 5'h1F, 32'h0);

        // Bypass hit and miss on a pending A write.
        cycle(1, 0, 1, 0, 10'h200, 5'h00, 10'h200, 5'h00, 32'h0000FFFF);
        cycle(0, 0, 0, 0, 10'h000, 5'h00, 10'h200, 5'h00, 32'h0);
        cycle(0, 0, 0, 0, 10'h000, 5'h00, 10'h201, 5'h00, 32'h0);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h200, 5'h00, 32'h0);

        // Stall holds a pending M write; release yields exactly one pulse.
        cycle(1, 0, 0, 1, 10'h000, 5'h03, 10'h003, 5'h03, 32'hCAFE0003);
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 0, 0, 10'h000, 5'h00, 10'h003, 5'h03, 32'h0);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h003, 5'h03, 32'h0);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h003, 5'h03, 32'h0);

        // Back-to-back writes to the same A address.
        cycle(1, 0, 1, 0, 10'h010, 5'h00, 10'h010, 5'h00, 32'h1);
        cycle(1, 0, 1, 0, 10'h010, 5'h00, 10'h010, 5'h00, 32'h2);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h010, 5'h00, 32'h0);

        // Both destinations: A goes to adest, M to mdest, no A mirror.
        cycle(1, 0, 1, 1, 10'h155, 5'h07, 10'h007, 5'h07, 32'h77775555);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h155, 5'h07, 32'h0);
        cycle(1, 0, 0, 0, 10'h000, 5'h00, 10'h007, 5'h07, 32'h0);

        // Random traffic over a small address window so hits are frequent.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                      1'($urandom), 1'($urandom),
                      AW'($urandom_range(0, 7)), MW'($urandom_range(0, 7)),
                      AW'($urandom_range(0, 7)), MW'($urandom_range(0, 7)),
                      $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
